// File: rtl/agc_seq_pkg.sv
// Shared definitions for the AGC scan sequencer: FSM states, result status codes
// and the per-channel register map of the wb_agc_ target block.
package agc_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SEL,
    S_WR_ARM,
    S_POLL_RD,
    S_POLL_GAP,
    S_RD_SQ,
    S_RD_GT,
    S_PUSH,
    S_FIN
  } seq_state_e;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_TIMEOUT = 2'd1;
  localparam logic [1:0] ST_BUSERR  = 2'd2;

  localparam logic [21:0] REG_CTRL = 22'h00;
  localparam logic [21:0] REG_STAT = 22'h04;
  localparam logic [21:0] REG_SQ   = 22'h08;
  localparam logic [21:0] REG_GT   = 22'h0C;

  localparam logic [31:0] ARM_WORD = 32'h1;

endpackage

// File: rtl/wb_classic_xfer.sv
// Single-access classic Wishbone master: a go pulse launches one registered cycle,
// done/err pulse the cycle after termination, with read data captured on ack.
module wb_classic_xfer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic        we,
  input  logic [21:0] adr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [21:0] wb_adr,
  output logic [31:0] wb_dat_w,
  output logic [3:0]  wb_sel,
  input  logic [31:0] wb_dat_r,
  input  logic        wb_ack,
  input  logic        wb_err,
  input  logic        wb_rty
);

  logic fail;
  logic term;

  // Retry is not retried here; the sequencer treats it exactly like an error.
  assign fail   = wb_err | wb_rty;
  assign term   = wb_cyc & (wb_ack | fail);
  assign wb_sel = 4'hF;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done     <= 1'b0;
      err      <= 1'b0;
      rdata    <= '0;
      wb_cyc   <= 1'b0;
      wb_stb   <= 1'b0;
      wb_we    <= 1'b0;
      wb_adr   <= '0;
      wb_dat_w <= '0;
    end else begin
      done <= term;
      err  <= term & fail;
      if (term) begin
        wb_cyc <= 1'b0;
        wb_stb <= 1'b0;
        if (!fail && !wb_we) rdata <= wb_dat_r;
      end else if (go && !wb_cyc) begin
        wb_cyc   <= 1'b1;
        wb_stb   <= 1'b1;
        wb_we    <= we;
        wb_adr   <= adr;
        wb_dat_w <= wdata;
      end
    end
  end

endmodule

// File: rtl/agc_scan_sequencer.sv
// Walks the enabled AGC channels: arm, poll STAT, read SQ and GT, and emit one
// result record per channel on a valid/ready stream.
module agc_scan_sequencer
  import agc_seq_pkg::*;
#(
  parameter int          NCHAN       = 8,
  parameter logic [21:0] CHAN_STRIDE = 22'h400,
  parameter int          POLL_LIMIT  = 1024,
  parameter int          POLL_GAP    = 16
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_n_i,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic [NCHAN-1:0]         chan_mask_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     aborted_o,
  output logic                     wb_agc_cyc_o,
  output logic                     wb_agc_stb_o,
  output logic                     wb_agc_we_o,
  output logic [21:0]              wb_agc_adr_o,
  output logic [31:0]              wb_agc_dat_o,
  output logic [3:0]               wb_agc_sel_o,
  input  logic [31:0]              wb_agc_dat_i,
  input  logic                     wb_agc_ack_i,
  input  logic                     wb_agc_err_i,
  input  logic                     wb_agc_rty_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [$clog2(NCHAN)-1:0] res_chan_o,
  output logic [31:0]              res_sq_o,
  output logic [31:0]              res_gt_o,
  output logic [1:0]               res_status_o
);

  localparam int CW     = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam int POLL_W = (POLL_LIMIT > 1) ? $clog2(POLL_LIMIT) : 1;
  localparam int GAP_W  = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  seq_state_e state_q, state_d;

  logic [NCHAN-1:0]  rem_q;
  logic [CW-1:0]     chan_q;
  logic [CW-1:0]     sel_idx;
  logic [POLL_W-1:0] poll_cnt_q;
  logic [GAP_W-1:0]  gap_q;
  logic              sent_q;
  logic              abort_q;
  logic [31:0]       sq_q;
  logic [31:0]       gt_q;
  logic [1:0]        status_q;

  logic              go;
  logic              x_we;
  logic [21:0]       x_off;
  logic [31:0]       x_wdata;
  logic              x_done;
  logic              x_err;
  logic [31:0]       x_rdata;
  logic              stop;
  logic              poll_last;
  logic              gap_last;

  assign poll_last = (poll_cnt_q == POLL_W'(POLL_LIMIT - 1));
  assign gap_last  = (gap_q == GAP_W'(POLL_GAP - 1));

  // Lowest set bit of the remaining mask; served bits are cleared, so order is ascending.
  always_comb begin
    sel_idx = '0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      if (rem_q[i]) sel_idx = CW'(i);
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) state_q <= S_IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    go          = 1'b0;
    x_we        = 1'b0;
    x_off       = REG_CTRL;
    x_wdata     = '0;
    busy_o      = 1'b1;
    done_o      = 1'b0;
    aborted_o   = 1'b0;
    res_valid_o = 1'b0;
    stop        = abort_q | abort_i;
    unique case (state_q)
      S_IDLE: begin
        busy_o = 1'b0;
        if (start_i) state_d = S_SEL;
      end
      S_SEL: begin
        if (stop || rem_q == '0) state_d = S_FIN;
        else                     state_d = S_WR_ARM;
      end
      S_WR_ARM: begin
        go      = !sent_q;
        x_we    = 1'b1;
        x_off   = REG_CTRL;
        x_wdata = ARM_WORD;
        if (x_done) state_d = stop ? S_FIN : (x_err ? S_PUSH : S_POLL_RD);
      end
      S_POLL_RD: begin
        go    = !sent_q;
        x_off = REG_STAT;
        if (x_done) begin
          if (stop)            state_d = S_FIN;
          else if (x_err)      state_d = S_PUSH;
          else if (x_rdata[0]) state_d = S_RD_SQ;
          else if (poll_last)  state_d = S_PUSH;
          else if (POLL_GAP == 0) state_d = S_POLL_RD;
          else                 state_d = S_POLL_GAP;
        end
      end
      S_POLL_GAP: begin
        if (stop)          state_d = S_FIN;
        else if (gap_last) state_d = S_POLL_RD;
      end
      S_RD_SQ: begin
        go    = !sent_q;
        x_off = REG_SQ;
        if (x_done) state_d = stop ? S_FIN : (x_err ? S_PUSH : S_RD_GT);
      end
      S_RD_GT: begin
        go    = !sent_q;
        x_off = REG_GT;
        if (x_done) state_d = stop ? S_FIN : S_PUSH;
      end
      S_PUSH: begin
        res_valid_o = 1'b1;
        if (res_ready_i) state_d = S_SEL;
      end
      S_FIN: begin
        busy_o    = 1'b0;
        done_o    = 1'b1;
        aborted_o = abort_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      rem_q      <= '0;
      chan_q     <= '0;
      poll_cnt_q <= '0;
      gap_q      <= '0;
      sent_q     <= 1'b0;
      abort_q    <= 1'b0;
      sq_q       <= '0;
      gt_q       <= '0;
      status_q   <= ST_OK;
    end else begin
      if (go)          sent_q <= 1'b1;
      else if (x_done) sent_q <= 1'b0;

      if (state_q == S_IDLE) abort_q <= 1'b0;
      else if (abort_i)      abort_q <= 1'b1;

      unique case (state_q)
        S_IDLE: if (start_i) rem_q <= chan_mask_i;
        S_SEL: begin
          if (!stop && rem_q != '0) begin
            chan_q         <= sel_idx;
            rem_q[sel_idx] <= 1'b0;
            poll_cnt_q     <= '0;
            sq_q           <= '0;
            gt_q           <= '0;
            status_q       <= ST_OK;
          end
        end
        S_WR_ARM: if (x_done && x_err) status_q <= ST_BUSERR;
        S_POLL_RD: begin
          if (x_done) begin
            if (x_err) status_q <= ST_BUSERR;
            else if (!x_rdata[0]) begin
              poll_cnt_q <= poll_cnt_q + POLL_W'(1);
              gap_q      <= '0;
              if (poll_last) status_q <= ST_TIMEOUT;
            end
          end
        end
        S_POLL_GAP: gap_q <= gap_q + GAP_W'(1);
        S_RD_SQ: begin
          if (x_done) begin
            if (x_err) status_q <= ST_BUSERR;
            else       sq_q     <= x_rdata;
          end
        end
        S_RD_GT: begin
          // An error on the last access still zeroes the SQ value already captured.
          if (x_done) begin
            if (x_err) begin
              status_q <= ST_BUSERR;
              sq_q     <= '0;
            end else begin
              gt_q <= x_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign res_chan_o   = chan_q;
  assign res_sq_o     = sq_q;
  assign res_gt_o     = gt_q;
  assign res_status_o = status_q;

  wb_classic_xfer u_xfer (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_n_i),
    .go       (go),
    .we       (x_we),
    .adr      (CHAN_STRIDE * 22'(chan_q) + x_off),
    .wdata    (x_wdata),
    .done     (x_done),
    .err      (x_err),
    .rdata    (x_rdata),
    .wb_cyc   (wb_agc_cyc_o),
    .wb_stb   (wb_agc_stb_o),
    .wb_we    (wb_agc_we_o),
    .wb_adr   (wb_agc_adr_o),
    .wb_dat_w (wb_agc_dat_o),
    .wb_sel   (wb_agc_sel_o),
    .wb_dat_r (wb_agc_dat_i),
    .wb_ack   (wb_agc_ack_i),
    .wb_err   (wb_agc_err_i),
    .wb_rty   (wb_agc_rty_i)
  );

endmodule

// File: tb/tb_agc_scan_sequencer.sv
// Directed bench for agc_scan_sequencer with a wait-state capable Wishbone slave
// model for the 8-channel AGC chain and a bus/record monitor.
module tb_agc_scan_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [7:0]  mask;
  logic        busy, done, aborted;
  logic        cyc, stb, we;
  logic [21:0] adr;
  logic [31:0] dat_o, dat_i;
  logic [3:0]  sel;
  logic        ack, errs, rty;
  logic        res_valid, res_ready;
  logic [2:0]  res_chan;
  logic [31:0] res_sq, res_gt;
  logic [1:0]  res_status;

  int total = 0;
  int bad   = 0;

  // Slave model controls
  int          ws = 0;
  int          wcnt = 0;
  logic [7:0]  never_done = 8'h00;
  logic        err_en = 1'b0;
  logic [2:0]  err_chan = 3'd0;
  logic [3:0]  err_off = 4'h0;
  logic [2:0]  s_chan;
  logic [3:0]  s_off;
  logic        s_err, s_hit;

  always #5 clk = ~clk;

  agc_scan_sequencer #(.NCHAN(8), .CHAN_STRIDE(22'h400), .POLL_LIMIT(4), .POLL_GAP(3)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .start_i(start), .abort_i(abort), .chan_mask_i(mask),
    .busy_o(busy), .done_o(done), .aborted_o(aborted),
    .wb_agc_cyc_o(cyc), .wb_agc_stb_o(stb), .wb_agc_we_o(we), .wb_agc_adr_o(adr),
    .wb_agc_dat_o(dat_o), .wb_agc_sel_o(sel), .wb_agc_dat_i(dat_i),
    .wb_agc_ack_i(ack), .wb_agc_err_i(errs), .wb_agc_rty_i(rty),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_chan_o(res_chan),
    .res_sq_o(res_sq), .res_gt_o(res_gt), .res_status_o(res_status)
  );

  assign s_chan = adr[12:10];
  assign s_off  = adr[3:0];
  assign s_err  = err_en && (s_chan == err_chan) && (s_off == err_off);
  assign s_hit  = cyc && stb && (wcnt >= ws);
  assign ack    = s_hit && !s_err;
  assign errs   = s_hit && s_err;
  assign rty    = 1'b0;

  always_comb begin
    dat_i = 32'h0;
    case (s_off)
      4'h4: dat_i = {31'b0, !never_done[s_chan]};
      4'h8: dat_i = 32'hA000_0011 | ({29'b0, s_chan} << 8);
      4'hC: dat_i = 32'hB000_0022 | ({29'b0, s_chan} << 8);
      default: dat_i = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (cyc && stb && !(ack || errs || rty)) wcnt <= wcnt + 1;
    else                                     wcnt <= 0;
  end

  // Bus and record monitor
  logic        log_clr = 1'b0;
  int          stat_rd[8], sq_rd[8], gt_rd[8], arm_wr[8];
  int          nrec, min_idle, min_stat_gap, idle_cnt, adr_viol;
  int          cyc_cnt = 0;
  logic        had_prev, prev_stat;
  logic        cyc_prev = 1'b0;
  logic [21:0] adr_prev = '0;
  logic [2:0]  rec_chan[16];
  logic [1:0]  rec_st[16];
  logic [31:0] rec_sq[16], rec_gt[16];
  logic        term_now;

  assign term_now = cyc && stb && (ack || errs || rty);

  always @(posedge clk) begin
    cyc_cnt  <= cyc_cnt + (cyc ? 1 : 0);
    cyc_prev <= cyc;
    adr_prev <= adr;
    if (log_clr) begin
      for (int i = 0; i < 8; i++) begin
        stat_rd[i] <= 0; sq_rd[i] <= 0; gt_rd[i] <= 0; arm_wr[i] <= 0;
      end
      nrec <= 0; min_idle <= 1000; min_stat_gap <= 1000; idle_cnt <= 0;
      adr_viol <= 0; had_prev <= 1'b0; prev_stat <= 1'b0;
    end else begin
      if (term_now) begin
        case (s_off)
          4'h0: if (we && dat_o == 32'h1) arm_wr[s_chan] <= arm_wr[s_chan] + 1;
          4'h4: stat_rd[s_chan] <= stat_rd[s_chan] + 1;
          4'h8: sq_rd[s_chan] <= sq_rd[s_chan] + 1;
          4'hC: gt_rd[s_chan] <= gt_rd[s_chan] + 1;
          default: ;
        endcase
        prev_stat <= (s_off == 4'h4);
      end
      if (cyc && !cyc_prev) begin
        if (had_prev && idle_cnt < min_idle) min_idle <= idle_cnt;
        if (prev_stat && s_off == 4'h4 && idle_cnt < min_stat_gap) min_stat_gap <= idle_cnt;
        had_prev <= 1'b1;
      end
      idle_cnt <= cyc ? 0 : idle_cnt + 1;
      if (cyc && cyc_prev && adr != adr_prev) adr_viol <= adr_viol + 1;
      if (res_valid && res_ready && nrec < 16) begin
        rec_chan[nrec] <= res_chan;
        rec_st[nrec]   <= res_status;
        rec_sq[nrec]   <= res_sq;
        rec_gt[nrec]   <= res_gt;
        nrec           <= nrec + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    @(negedge clk); log_clr = 1'b1;
    @(negedge clk); log_clr = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] m);
    @(negedge clk); mask = m; start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output logic ab);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 64'(done), 64'd1);
    ab = aborted;
  endtask

  task automatic wait_bus(input logic [21:0] a, input int budget);
    int n;
    n = 0;
    while (!(cyc && adr == a) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("bus_seen", 64'(cyc && adr == a), 64'd1);
  endtask

  initial begin
    logic        ab;
    int          n, c0, s0, unstable;
    logic [2:0]  snap_chan;
    logic [31:0] snap_sq, snap_gt;
    logic [1:0]  snap_st;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mask = 8'h00; res_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_cyc", 64'(cyc), 64'd0);
    check("rst_valid", 64'(res_valid), 64'd0);
    check("rst_adr", 64'(adr), 64'd0);
    check("sel_const", 64'(sel), 64'hF);
    rst_n = 1'b1;

    // Empty mask: done two cycles after start
    do_start(8'h00);
    check("m0_busy", 64'(busy), 64'd1);
    check("m0_done_early", 64'(done), 64'd0);
    @(negedge clk);
    check("m0_done", 64'(done), 64'd1);
    check("m0_aborted", 64'(aborted), 64'd0);

    // Mask 0x05, zero wait states
    clear_log();
    do_start(8'h05);
    wait_done(500, ab);
    check("t1_aborted", 64'(ab), 64'd0);
    check("t1_nrec", 64'(nrec), 64'd2);
    check("t1_chan0", 64'(rec_chan[0]), 64'd0);
    check("t1_chan1", 64'(rec_chan[1]), 64'd2);
    check("t1_st0", 64'(rec_st[0]), 64'd0);
    check("t1_st1", 64'(rec_st[1]), 64'd0);
    check("t1_sq0", 64'(rec_sq[0]), 64'hA000_0011);
    check("t1_gt0", 64'(rec_gt[0]), 64'hB000_0022);
    check("t1_sq2", 64'(rec_sq[1]), 64'hA000_0211);
    check("t1_gt2", 64'(rec_gt[1]), 64'hB000_0222);
    check("t1_arm0", 64'(arm_wr[0]), 64'd1);
    check("t1_stat0", 64'(stat_rd[0]), 64'd1);
    check("t1_arm1", 64'(arm_wr[1]), 64'd0);
    check("t1_idle_gap", 64'(min_idle >= 1), 64'd1);
    check("t1_adr_stable", 64'(adr_viol), 64'd0);

    // Channel 3 never reports done: timeout after four STAT reads
    clear_log();
    never_done = 8'h08;
    do_start(8'h08);
    wait_done(1000, ab);
    check("t2_nrec", 64'(nrec), 64'd1);
    check("t2_chan", 64'(rec_chan[0]), 64'd3);
    check("t2_status", 64'(rec_st[0]), 64'd1);
    check("t2_sq", 64'(rec_sq[0]), 64'd0);
    check("t2_gt", 64'(rec_gt[0]), 64'd0);
    check("t2_stat_reads", 64'(stat_rd[3]), 64'd4);
    check("t2_sq_reads", 64'(sq_rd[3]), 64'd0);
    check("t2_poll_gap", 64'(min_stat_gap >= 3), 64'd1);
    never_done = 8'h00;

    // Bus error on the channel 1 SQ read
    clear_log();
    err_en = 1'b1; err_chan = 3'd1; err_off = 4'h8;
    do_start(8'h06);
    wait_done(500, ab);
    check("t3_nrec", 64'(nrec), 64'd2);
    check("t3_chan1", 64'(rec_chan[0]), 64'd1);
    check("t3_st1", 64'(rec_st[0]), 64'd2);
    check("t3_sq1", 64'(rec_sq[0]), 64'd0);
    check("t3_gt1", 64'(rec_gt[0]), 64'd0);
    check("t3_gt_rd1", 64'(gt_rd[1]), 64'd0);
    check("t3_chan2", 64'(rec_chan[1]), 64'd2);
    check("t3_st2", 64'(rec_st[1]), 64'd0);
    check("t3_gt2", 64'(rec_gt[1]), 64'hB000_0222);
    err_en = 1'b0;

    // Back-pressure for 50 cycles
    clear_log();
    res_ready = 1'b0;
    do_start(8'h01);
    n = 0;
    while (!res_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("t4_valid", 64'(res_valid), 64'd1);
    snap_chan = res_chan; snap_sq = res_sq; snap_gt = res_gt; snap_st = res_status;
    c0 = cyc_cnt;
    unstable = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!res_valid || res_chan != snap_chan || res_sq != snap_sq ||
          res_gt != snap_gt || res_status != snap_st) unstable++;
    end
    check("t4_stable", 64'(unstable), 64'd0);
    check("t4_sq", 64'(snap_sq), 64'hA000_0011);
    check("t4_no_cyc", 64'(cyc_cnt - c0), 64'd0);
    res_ready = 1'b1;
    wait_done(200, ab);
    check("t4_nrec", 64'(nrec), 64'd1);

    // Abort during the channel 4 poll with three wait states
    clear_log();
    ws = 3; never_done = 8'h10;
    do_start(8'h30);
    wait_bus(22'h001004, 500);
    s0 = stat_rd[4];
    abort = 1'b1;
    wait_done(200, ab);
    check("t5_aborted", 64'(ab), 64'd1);
    check("t5_stat_acked", 64'(stat_rd[4]), 64'(s0 + 1));
    abort = 1'b0;
    c0 = cyc_cnt;
    repeat (20) @(negedge clk);
    check("t5_no_cyc", 64'(cyc_cnt - c0), 64'd0);
    check("t5_chan5_untouched", 64'(arm_wr[5]), 64'd0);
    check("t5_idle", 64'(busy), 64'd0);
    never_done = 8'h00;

    // Reset in the middle of the SQ read, then a clean scan
    ws = 5;
    do_start(8'h01);
    wait_bus(22'h000008, 500);
    rst_n = 1'b0;
    #1;
    check("t6_cyc", 64'(cyc), 64'd0);
    check("t6_stb", 64'(stb), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_valid", 64'(res_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ws = 0;
    clear_log();
    do_start(8'h80);
    wait_done(500, ab);
    check("t6_nrec", 64'(nrec), 64'd1);
    check("t6_chan", 64'(rec_chan[0]), 64'd7);
    check("t6_status", 64'(rec_st[0]), 64'd0);
    check("t6_gt", 64'(rec_gt[0]), 64'hB000_0722);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
